// File: rtl/spi_flash_xip_ctrl_if.sv
// rtl/spi_flash_xip_ctrl_if.sv - Wishbone read-port bundle for the SPI flash XIP controller
//
// Signals:
//   wb_adr_i[23:0]  byte address from master (bits [1:0] ignored by the slave)
//   wb_dat_i[31:0]  write data from master (ignored, port is read-only)
//   wb_sel_i[3:0]   byte selects from master (ignored)
//   wb_we_i         write enable from master
//   wb_cyc_i        bus cycle from master
//   wb_stb_i        strobe from master
//   wb_dat_o[31:0]  big-endian read data to master
//   wb_ack_o        single-cycle read acknowledge to master
//   wb_err_o        single-cycle write error to master
interface spi_flash_xip_ctrl_if;
    logic [23:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/spi_flash_xip_ctrl.sv
// rtl/spi_flash_xip_ctrl.sv - read-only Wishbone slave mapping an SPI NOR flash (READ 0x03)
//
// Ports:
//   wb_clk_i    system clock
//   wb_rst_i    asynchronous active-high reset
//   wb          Wishbone slave bundle (spi_flash_xip_ctrl_if.slave)
//   spi_sck_o   SPI clock, mode 0 (idles low)
//   spi_mosi_o  command/address bits to the flash, MSB first
//   spi_miso_i  data bits from the flash, sampled on SCK rise
//   spi_ss_o    chip select, active low; held low between contiguous reads
module spi_flash_xip_ctrl #(
    parameter int CLK_DIV      = 2,
    parameter int DESEL_CYCLES = 4,
    parameter int HOLD_TIMEOUT = 256
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    spi_flash_xip_ctrl_if.slave wb,
    output logic                spi_sck_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i,
    output logic                spi_ss_o
);
    localparam int DW = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int CW = (DESEL_CYCLES > 1) ? $clog2(DESEL_CYCLES) : 1;
    localparam int IW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DESEL_LAST = CW'(DESEL_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
    localparam logic [7:0]    CMD_READ   = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ACK,
        HOLD,
        DESEL
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [30:0]   tx_sr;       // bits still to send after the one on spi_mosi_o
    logic [31:0]   rx_sr;
    logic [23:0]   lat_adr;
    logic [23:2]   next_adr;    // word address the flash will deliver next
    logic          pend;        // a read is waiting behind the current deselect
    logic [IW-1:0] idle_cnt;
    logic [CW-1:0] desel_cnt;

    logic [31:0]   dat_q;
    logic          ack_q;
    logic          err_q;
    logic          sck_q;
    logic          mosi_q;
    logic          ss_q;

    logic          rd_req;
    logic          wr_req;
    logic [23:0]   req_adr;
    logic [23:0]   cmd_adr;
    logic          contig;
    logic          shifting;
    logic          tick;
    logic          bit_end;
    logic          timeout;
    logic          unused_ok;

    assign rd_req   = wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_we_i;
    // err_q masks the strobe the master still holds during the err cycle,
    // so one write produces exactly one error pulse.
    assign wr_req   = wb.wb_cyc_i && wb.wb_stb_i && wb.wb_we_i && !err_q;
    assign req_adr  = {wb.wb_adr_i[23:2], 2'b00};
    assign cmd_adr  = (state == IDLE) ? req_adr : lat_adr;
    assign contig   = (wb.wb_adr_i[23:2] == next_adr);
    assign shifting = (state == CMD) || (state == ADDR) || (state == DATA);
    assign tick     = (div_cnt == DIV_LAST);
    assign bit_end  = shifting && tick && sck_q;
    assign timeout  = (HOLD_TIMEOUT != 0) && (idle_cnt == IDLE_LAST);
    assign unused_ok = ^{wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[1:0]};

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign spi_sck_o   = sck_q;
    assign spi_mosi_o  = mosi_q;
    assign spi_ss_o    = ss_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (rd_req) state_nx = CMD;
            CMD:   if (bit_end && bit_cnt == 6'd7) state_nx = ADDR;
            ADDR:  if (bit_end && bit_cnt == 6'd31) state_nx = DATA;
            // Fresh reads end at bit 63, streamed reads at bit 31.
            DATA:  if (bit_end && bit_cnt[4:0] == 5'd31) state_nx = ACK;
            ACK:   state_nx = HOLD;
            HOLD: begin
                if (rd_req) begin
                    state_nx = contig ? DATA : DESEL;
                end else if (timeout) begin
                    state_nx = DESEL;
                end
            end
            DESEL: if (desel_cnt == DESEL_LAST) state_nx = pend ? CMD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            lat_adr   <= '0;
            next_adr  <= '0;
            pend      <= 1'b0;
            idle_cnt  <= '0;
            desel_cnt <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= wr_req && ((state == IDLE) || (state == HOLD));
            ss_q  <= (state_nx == IDLE) || (state_nx == DESEL);

            // Bit engine: SCK low for CLK_DIV cycles, then high for CLK_DIV.
            if (shifting) begin
                if (tick) begin
                    div_cnt <= '0;
                    sck_q   <= !sck_q;
                    if (!sck_q) begin
                        if (state == DATA) begin
                            rx_sr <= {rx_sr[30:0], spi_miso_i};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (state != DATA) begin
                            {mosi_q, tx_sr} <= {tx_sr, 1'b0};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end

            idle_cnt  <= (state == HOLD)  ? idle_cnt + IW'(1)  : '0;
            desel_cnt <= (state == DESEL) ? desel_cnt + CW'(1) : '0;

            if (state == DATA && state_nx == ACK) begin
                next_adr <= lat_adr[23:2] + 22'd1;
                // A master that abandoned the cycle gets nothing; the flash
                // pointer still advanced, so next_adr moves on regardless.
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    ack_q <= 1'b1;
                    dat_q <= rx_sr;
                end
            end

            if (state == HOLD && rd_req) begin
                lat_adr <= req_adr;
                pend    <= !contig;
            end

            if (state == HOLD && state_nx == DATA) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                sck_q   <= 1'b0;
                mosi_q  <= 1'b0;
            end

            if (state_nx == CMD && state != CMD) begin
                lat_adr         <= cmd_adr;
                {mosi_q, tx_sr} <= {CMD_READ, cmd_adr};
                div_cnt         <= '0;
                bit_cnt         <= '0;
                sck_q           <= 1'b0;
                pend            <= 1'b0;
            end
        end
    end
endmodule

// File: doc/spi_flash_xip_ctrl.md
# spi_flash_xip_ctrl

Read-only Wishbone slave that maps the board's SPI NOR flash (s25fl064p class, READ 0x03) into the CPU address space. Each bus read is sequenced into an SPI command, 24-bit address and 32-bit data phase. Chip select is held low between accesses so that sequential word reads stream without re-sending command and address. It sits between the SoC Wishbone interconnect and the spi0 flash pads, alongside the boot ROM, for execute-in-place and image loading.

## Interface
- CLK_DIV, 2: SCK half-period in wb_clk_i cycles (≥1).
- DESEL_CYCLES, 4: minimum spi_ss_o high time in wb_clk_i cycles between non-contiguous accesses (≥1).
- HOLD_TIMEOUT, 256: idle cycles with ss low before auto-deselect; 0 disables the timeout.

- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_adr_i  in  24  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  ignored.
- wb_sel_i  in  4  ignored.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data, big-endian.
- wb_ack_o  out  1  read acknowledge, single cycle.
- wb_err_o  out  1  write error, single cycle.
- spi_sck_o  out  1  SPI clock, mode 0.
- spi_mosi_o  out  1  SPI data to flash.
- spi_miso_i  in  1  SPI data from flash.
- spi_ss_o  out  1  chip select, active low.

## Operation
- Reset values: wb_dat_o=0, wb_ack_o=0, wb_err_o=0, spi_sck_o=0, spi_mosi_o=0, spi_ss_o=1. State is IDLE and next_adr=0.
- States: IDLE, CMD, ADDR, DATA, ACK, HOLD, DESEL.
- IDLE: spi_ss_o=1.
  - cyc&stb&we → wb_err_o for 1 cycle; state stays IDLE.
  - cyc&stb&!we → latch {wb_adr_i[23:2],2'b00}; go to CMD.
- CMD: shift 8'h03 MSB first. ADDR: shift the 24-bit latched address MSB first.
- DATA: shift in 32 bits MSB first; MOSI=0. The first received byte goes to wb_dat_o[31:24].
- ACK: wb_dat_o is loaded and wb_ack_o is pulsed if cyc&stb are still high. If the master dropped cyc, data is discarded and no ack is issued. next_adr = latched+4 mod 2^24. Go to HOLD.
- HOLD: spi_ss_o=0, SCK low. The idle counter starts at 0.
  - Read with wb_adr_i[23:2]==next_adr[23:2] → DATA directly (streaming).
  - Read at any other address → DESEL, then fresh CMD.
  - Write → wb_err_o for 1 cycle; stay in HOLD; the idle counter continues.
  - Idle counter reaching HOLD_TIMEOUT (if nonzero) → DESEL, then IDLE.
- DESEL: spi_ss_o=1 for exactly DESEL_CYCLES cycles, then go to CMD (pending read) or IDLE.
- Wrap: next_adr 0xFFFFFC+4 → 0x000000 counts as contiguous. The flash wraps its own address counter accordingly.
- Bit counter is 6 bits, counting 0..63 fresh or 0..31 streaming. SCK divider counter is ceil(log2(CLK_DIV)) bits.
- Async reset asserted mid-transfer forces the reset values immediately; spi_ss_o rising aborts the flash read.

## Timing
- SPI mode 0: SCK idles low. MOSI changes while SCK is low (at ss fall or SCK fall). MISO is sampled on the SCK rising edge.
- Each bit period is 2*CLK_DIV cycles: SCK is low for CLK_DIV, then high for CLK_DIV.
- Fresh read, stb first seen in IDLE at cycle T:
  - spi_ss_o falls at T+1, with MOSI = cmd bit 7.
  - 64 SCK pulses follow.
  - wb_ack_o is high at cycle T+1+128*CLK_DIV (CLK_DIV=2 → T+257).
- Streaming read, stb seen in HOLD at cycle T: 32 pulses; ack at T+1+64*CLK_DIV (T+129).
- Non-contiguous read from HOLD at T:
  - ss rises at T+1 and stays high DESEL_CYCLES cycles.
  - ss falls at T+1+DESEL_CYCLES.
  - ack at T+1+DESEL_CYCLES+128*CLK_DIV.
- Write: wb_err_o high at T+1 for one cycle; wb_ack_o is never asserted for writes.
- Ack and err are single-cycle. The master must deassert stb the cycle after ack; a held stb is treated as a new request.
- SCK is low whenever spi_ss_o is high and during ACK/HOLD.

## Test plan
- Reset: hold wb_rst_i high, toggle clock → all outputs at reset values; ss=1, sck=0. Assert reset mid-DATA → ss=1, sck=0 within the same cycle, no ack.
- Fresh read at 0x000100, flash preloaded with 0xDE,0xAD,0xBE,0xEF at 0x100 → MOSI shows 0x03,0x00,0x01,0x00; wb_dat_o=0xDEADBEEF; ack at T+257.
- Streaming: after that read, read 0x000104 (bytes 0x01,0x02,0x03,0x04) → no command re-sent, ss stays low, dat=0x01020304, ack at T+129.
- Non-contiguous: read 0x000200 from HOLD → ss high for exactly 4 cycles, new command 0x03,0x00,0x02,0x00, correct data.
- Write to 0x000000 in IDLE and in HOLD → single-cycle wb_err_o at T+1, no SCK activity, HOLD preserved.
- Timeout/abort/wrap:
  - 256 idle cycles in HOLD → ss rises, state IDLE.
  - cyc dropped mid-DATA → no ack, next contiguous read streams.
  - Read 0xFFFFFC then 0x000000 → second read streams.
